// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: ROM, decode-handshake, redirect and status signals of the fetch sequencer
//   master: fetch sequencer side (drives ROM address, fetch register, status)
//   slave : environment side (ROM data, decode ready, branch redirect)
interface instr_fetch_ctrl_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] inst_out;
  logic [63:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  modport master(
    output imem_addr, inst_out, pc_out, inst_valid, halted, misalign_err, fetch_count, stall_count,
    input  imem_instr, inst_ready, redirect_valid, redirect_target
  );
  modport slave(
    input  imem_addr, inst_out, pc_out, inst_valid, halted, misalign_err, fetch_count, stall_count,
    output imem_instr, inst_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer feeding a one-entry fetch register to decode over valid/ready
//   clk, reset   : clock, asynchronous active-high reset
//   bus (master) : imem_addr/imem_instr ROM port, inst_out/pc_out/inst_valid/inst_ready to decode,
//                  redirect_valid/redirect_target branch input, halted/misalign_err status,
//                  fetch_count/stall_count performance counters
//   IFETCH_PERF_CNT_EN : when defined, saturating transfer and stall counters; otherwise both read 0
module instr_fetch_ctrl #(
  parameter int          MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              reset,
  instr_fetch_ctrl_if.master bus
);
  typedef enum logic {RUN, HALT} state_t;
  // pc+3 < MEM_SIZE rewritten as pc < MEM_SIZE-3 so huge PCs cannot wrap into range
  localparam logic [63:0] LIMIT = 64'(MEM_SIZE - 3);
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d, mis_q, mis_d;
  logic        pc_ok, tgt_ok, transfer, load;
  assign pc_ok    = pc_q < LIMIT;
  assign tgt_ok   = bus.redirect_target < LIMIT;
  assign transfer = valid_q & bus.inst_ready;
  assign load     = (state_q == RUN) & pc_ok & (!valid_q | bus.inst_ready) & !bus.redirect_valid;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    mis_d    = mis_q;
    if (bus.redirect_valid) begin
      valid_d = 1'b0;
      if (|bus.redirect_target[1:0]) begin
        state_d = HALT;
        mis_d   = 1'b1;
      end else begin
        pc_d    = bus.redirect_target;
        state_d = tgt_ok ? RUN : HALT;
      end
    end else if (load) begin
      inst_d   = bus.imem_instr;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + 64'd4;
    end else begin
      valid_d = transfer ? 1'b0 : valid_q;
      state_d = (state_q == RUN && !pc_ok) ? HALT : state_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
    end
  end
  assign bus.imem_addr    = pc_q;
  assign bus.inst_out     = inst_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.inst_valid   = valid_q;
  assign bus.halted       = state_q == HALT;
  assign bus.misalign_err = mis_q;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_q, fetch_d, stall_q, stall_d;
  always_comb begin
    fetch_d = (transfer && !(&fetch_q)) ? fetch_q + 32'd1 : fetch_q;
    stall_d = (valid_q && !bus.inst_ready && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end
  assign bus.fetch_count = fetch_q;
  assign bus.stall_count = stall_q;
`else
  assign bus.fetch_count = '0;
  assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: randomized + directed bench with a behavioural fetch-sequencer model
module tb_instr_fetch_ctrl;
  localparam int MEM_SIZE = 1024;
`ifdef IFETCH_PERF_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  logic [31:0] rom [256];
  instr_fetch_ctrl_if bus();
  instr_fetch_ctrl #(.MEM_SIZE(MEM_SIZE), .RESET_PC(64'd0)) dut (.clk(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_instr = (bus.imem_addr < 64'(MEM_SIZE)) ? rom[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Behavioural model: one fetch-register entry, a PC and a running flag
  logic [63:0] m_pc, m_pco;
  logic [31:0] m_inst, m_fc, m_sc;
  logic        m_run, m_valid, m_mis;
  function automatic bit legal(input logic [63:0] a);
    return a < 64'(MEM_SIZE - 3);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 64'd0; m_pco <= 64'd0; m_inst <= 32'd0; m_run <= 1'b1;
      m_valid <= 1'b0; m_mis <= 1'b0; m_fc <= 32'd0; m_sc <= 32'd0;
    end else begin
      if (m_valid && bus.inst_ready && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
      if (m_valid && !bus.inst_ready && m_sc != 32'hFFFF_FFFF) m_sc <= m_sc + 1;
      if (bus.redirect_valid) begin
        m_valid <= 1'b0;
        if (bus.redirect_target[1:0] != 2'b00) begin
          m_run <= 1'b0;
          m_mis <= 1'b1;
        end else begin
          m_pc  <= bus.redirect_target;
          m_run <= legal(bus.redirect_target);
        end
      end else if (m_run && legal(m_pc) && (!m_valid || bus.inst_ready)) begin
        m_inst  <= rom[m_pc[9:2]];
        m_pco   <= m_pc;
        m_valid <= 1'b1;
        m_pc    <= m_pc + 4;
      end else begin
        if (m_valid && bus.inst_ready) m_valid <= 1'b0;
        if (!legal(m_pc)) m_run <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("inst_valid", 64'(bus.inst_valid), 64'(m_valid));
      chk("inst_out", 64'(bus.inst_out), 64'(m_inst));
      chk("pc_out", bus.pc_out, m_pco);
      chk("halted", 64'(bus.halted), 64'(!m_run));
      chk("misalign_err", 64'(bus.misalign_err), 64'(m_mis));
      chk("fetch_count", 64'(bus.fetch_count), CNT ? 64'(m_fc) : 64'd0);
      chk("stall_count", 64'(bus.stall_count), CNT ? 64'(m_sc) : 64'd0);
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(bus.inst_valid), 64'd0);
    chk({tag, "_inst"}, 64'(bus.inst_out), 64'd0);
    chk({tag, "_pc_out"}, bus.pc_out, 64'd0);
    chk({tag, "_addr"}, bus.imem_addr, 64'd0);
    chk({tag, "_halted"}, 64'(bus.halted), 64'd0);
    chk({tag, "_mis"}, 64'(bus.misalign_err), 64'd0);
    chk({tag, "_fc"}, 64'(bus.fetch_count), 64'd0);
    chk({tag, "_sc"}, 64'(bus.stall_count), 64'd0);
  endtask

  task automatic redirect(input logic [63:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = t;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] last_pc;
    logic [63:0] t;
    int          n;
    for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 + 32'(i);
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 64'd0;
    repeat (2) @(negedge clk);
    reset_vals("reset");
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("first_valid", 64'(bus.inst_valid), 64'd1);
    chk("first_inst", 64'(bus.inst_out), 64'h1000_0000);
    chk("first_pc", bus.pc_out, 64'd0);
    @(negedge clk);
    chk("second_inst", 64'(bus.inst_out), 64'h1000_0001);
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_inst", 64'(bus.inst_out), 64'h1000_0001);
      chk("stall_pc_out", bus.pc_out, 64'd4);
      chk("stall_addr", bus.imem_addr, 64'd8);
    end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("resume_inst", 64'(bus.inst_out), 64'h1000_0002);
    chk("resume_pc", bus.pc_out, 64'd8);
    redirect(64'h40);
    chk("flush_valid", 64'(bus.inst_valid), 64'd0);
    chk("flush_addr", bus.imem_addr, 64'h40);
    @(negedge clk);
    chk("redir_inst", 64'(bus.inst_out), 64'h1000_0010);
    chk("redir_pc", bus.pc_out, 64'h40);
    last_pc = 64'd0;
    n = 0;
    while (!(bus.halted && !bus.inst_valid) && n < 3000) begin
      if (bus.inst_valid) last_pc = bus.pc_out;
      bus.inst_ready = ($urandom % 4) != 0;
      @(negedge clk);
      n++;
    end
    chk("run_timeout", 64'(n < 3000), 64'd1);
    chk("last_pc", last_pc, 64'h3FC);
    chk("end_addr", bus.imem_addr, 64'h400);
    chk("end_halted", 64'(bus.halted), 64'd1);
    bus.inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_idle", 64'(bus.inst_valid), 64'd0);
    redirect(64'h0);
    chk("unhalt", 64'(bus.halted), 64'd0);
    @(negedge clk);
    chk("restart_inst", 64'(bus.inst_out), 64'h1000_0000);
    redirect(64'h22);
    chk("mis_halt", 64'(bus.halted), 64'd1);
    chk("mis_err", 64'(bus.misalign_err), 64'd1);
    repeat (2) @(negedge clk);
    redirect(64'h8);
    chk("mis_resume", 64'(bus.halted), 64'd0);
    chk("mis_sticky", 64'(bus.misalign_err), 64'd1);
    @(negedge clk);
    chk("mis_inst", 64'(bus.inst_out), 64'h1000_0002);
    chk("mis_pc", bus.pc_out, 64'h8);
    redirect(64'h1000);
    chk("oor_halt", 64'(bus.halted), 64'd1);
    chk("oor_addr", bus.imem_addr, 64'h1000);
    for (int i = 0; i < 600; i++) begin
      bus.inst_ready = ($urandom % 3) != 0;
      bus.redirect_valid = ($urandom % 12) == 0;
      case ($urandom % 6)
        0, 1: t = {54'd0, 8'($urandom), 2'b00};
        2: t = {54'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        3: t = 64'h3FC;
        4: t = 64'h400;
        default: t = 64'hFFFF_FFFF_FFFF_FFFC;
      endcase
      bus.redirect_target = t;
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus.inst_ready = 1'b0;
    repeat (4) @(negedge clk);
    bus.inst_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("fetch_count_10", 64'(bus.fetch_count), CNT ? 64'd10 : 64'd0);
    chk("stall_count_4", 64'(bus.stall_count), CNT ? 64'd4 : 64'd0);
    bus.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    reset_vals("midstall");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
